// File: rtl/vram_arbiter.sv
// ============================================================================
//  Module      : vram_arbiter
//  Description : Single-port VRAM arbiter: display fetch, CPU write queue and
//                clear engine. Optional statistics ports: VRAM_ARB_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vram_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int VRAM_SIZE  = 19200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [7:0]        disp_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              clr_start,
    input  logic [7:0]        clr_value,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
`ifdef VRAM_ARB_STATS_EN
    input  logic [7:0]        ram_rdata,
    output logic [15:0]       stall_cnt,
    output logic [7:0]        drop_cnt
`else
    input  logic [7:0]        ram_rdata
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(VRAM_SIZE - 1);
    localparam logic [ADDR_W:0]   SIZE_EXT   = (ADDR_W+1)'(VRAM_SIZE);
    localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(FIFO_DEPTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [7:0]        clr_value_q, clr_value_d;
    logic              disp_valid_q, disp_valid_d;

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr_d [FIFO_DEPTH];
    logic [7:0]        fifo_data_q [FIFO_DEPTH];
    logic [7:0]        fifo_data_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              clearing;
    logic              fifo_empty;
    logic              fifo_full;
    logic              grant_disp;
    logic              grant_clr;
    logic              grant_fifo;
    logic              push;
    logic              pop;
    logic              clr_accept;
    logic [ADDR_W-1:0] head_addr;
    logic [7:0]        head_data;
    logic              head_in_range;

    assign clearing      = (state_q == ST_CLEAR);
    assign fifo_empty    = (count_q == '0);
    assign fifo_full     = (count_q == DEPTH_CNT);
    assign head_addr     = fifo_addr_q[rd_ptr_q];
    assign head_data     = fifo_data_q[rd_ptr_q];
    assign head_in_range = ({1'b0, head_addr} < SIZE_EXT);

    // Fixed priority: display, then clear engine, then queue head (held during a clear)
    assign grant_disp = !reset && disp_req;
    assign grant_clr  = !reset && !disp_req && clearing;
    assign grant_fifo = !reset && !disp_req && !clearing && !fifo_empty;

    assign wr_ready   = !reset && !fifo_full;
    assign push       = wr_valid && wr_ready;
    assign pop        = grant_fifo;
    assign clr_accept = !reset && clr_start && !clearing;

    // ------------------------------------------------------------------
    // RAM port, combinational from this cycle's grant
    // ------------------------------------------------------------------
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (grant_disp) begin
            ram_addr = disp_addr;
        end else if (grant_clr) begin
            ram_addr  = clr_cnt_q;
            ram_we    = 1'b1;
            ram_wdata = clr_value_q;
        end else if (grant_fifo) begin
            ram_addr  = head_addr;
            ram_we    = head_in_range;
            ram_wdata = head_data;
        end
    end

    assign disp_valid_d = grant_disp;
    assign disp_valid   = disp_valid_q && !reset;
    assign disp_data    = ram_rdata;

    // ------------------------------------------------------------------
    // Clear FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (grant_clr && (clr_cnt_q == LAST_ADDR)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        clr_busy = clearing && !reset;
    end

    always_comb begin
        clr_cnt_d   = clr_cnt_q;
        clr_value_d = clr_value_q;
        if (clr_accept) begin
            clr_cnt_d   = '0;
            clr_value_d = clr_value;
        end else if (grant_clr) begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // CPU write queue
    // ------------------------------------------------------------------
    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_addr_d[wr_ptr_q] = wr_addr;
            fifo_data_d[wr_ptr_q] = wr_data;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            clr_cnt_q    <= '0;
            clr_value_q  <= '0;
            disp_valid_q <= 1'b0;
            fifo_addr_q  <= '{default: '0};
            fifo_data_q  <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            clr_cnt_q    <= clr_cnt_d;
            clr_value_q  <= clr_value_d;
            disp_valid_q <= disp_valid_d;
            fifo_addr_q  <= fifo_addr_d;
            fifo_data_q  <= fifo_data_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    // An accepted clr_start wins over a same-cycle increment
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (clr_accept) begin
            stall_cnt_d = '0;
            drop_cnt_d  = '0;
        end else begin
            if (!fifo_empty && !grant_fifo && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
            if (grant_fifo && !head_in_range && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule

`default_nettype wire
